// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: byte-lane extraction for loads, read-modify-write
// for sub-word stores against a word-only data memory, and misalignment handling.
module mem_access_unit #(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc_misaligned,
    output logic [31:0] exc_addr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_read,
    output logic        dm_write,
    input  logic [31:0] dm_rdata
);
    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                           OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

    typedef enum logic [0:0] {IDLE, RMW_WR} state_t;
    state_t state, state_nx;

    logic [31:0] rmw_addr, rmw_data;
    logic        accept, is_word, is_half, is_load, is_sub_st, misaligned, trap, go;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic [31:0] lane, ext, wmask, merged;

    assign ready  = (state == IDLE) && !reset;
    assign accept = req_valid && ready;

    always_comb begin
        is_word    = (req_op == OP_LW) || (req_op == OP_SW);
        is_half    = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        is_load    = (req_op <= OP_LBU);
        is_sub_st  = (req_op == OP_SH) || (req_op == OP_SB);
        misaligned = is_word ? (req_addr[1:0] != 2'b00) : (is_half && req_addr[0]);
        trap       = MISALIGN_TRAP && misaligned;
        go         = accept && !trap;
        // Without trapping, the low bits are simply dropped to natural alignment.
        off        = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);
        sh         = {off, 3'b000};
        lane       = dm_rdata >> sh;
        case (req_op)
            OP_LB:   ext = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  ext = {24'h0, lane[7:0]};
            OP_LH:   ext = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  ext = {16'h0, lane[15:0]};
            default: ext = dm_rdata;
        endcase
        wmask  = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged = (dm_rdata & ~wmask) | ((req_wdata << sh) & wmask);
    end

    always_comb begin
        state_nx = state;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = {req_addr[31:2], 2'b00};
        dm_wdata = req_wdata;
        case (state)
            IDLE: begin
                if (go) begin
                    dm_read  = is_load || is_sub_st;
                    dm_write = (req_op == OP_SW);
                    if (is_sub_st) state_nx = RMW_WR;
                end
            end
            RMW_WR: begin
                dm_addr  = rmw_addr;
                dm_wdata = rmw_data;
                dm_write = !reset;  // a reset here drops the pending store
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rmw_addr       <= 32'h0;
            rmw_data       <= 32'h0;
            load_data      <= 32'h0;
            load_valid     <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_addr       <= 32'h0;
        end else begin
            state          <= state_nx;
            load_valid     <= go && is_load;
            exc_misaligned <= accept && trap;
            if (go && is_load) load_data <= ext;
            if (go && is_sub_st) begin
                rmw_addr <= {req_addr[31:2], 2'b00};
                rmw_data <= merged;
            end
            if (accept && trap) exc_addr <= req_addr;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: trapping instance plus a non-trapping instance,
// each with its own word-wide memory model.
module tb_mem_access_unit;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

    logic        ready, load_valid, exc_misaligned, dm_read, dm_write;
    logic [31:0] load_data, exc_addr, dm_addr, dm_wdata, dm_rdata;
    logic        ready0, load_valid0, exc_misaligned0, dm_read0, dm_write0;
    logic [31:0] load_data0, exc_addr0, dm_addr0, dm_wdata0, dm_rdata0;

    logic [31:0] mem  [0:15] = '{4: 32'h8899AABB, default: 32'h0};
    logic [31:0] mem0 [0:15] = '{4: 32'h8899AABB, default: 32'h0};

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign dm_rdata  = mem[dm_addr[5:2]];
    assign dm_rdata0 = mem0[dm_addr0[5:2]];
    always @(posedge clk) if (dm_write) mem[dm_addr[5:2]] <= dm_wdata;
    always @(posedge clk) if (dm_write0) mem0[dm_addr0[5:2]] <= dm_wdata0;

    mem_access_unit #(.MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready),
        .load_data(load_data), .load_valid(load_valid), .exc_misaligned(exc_misaligned),
        .exc_addr(exc_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_read(dm_read),
        .dm_write(dm_write), .dm_rdata(dm_rdata));

    mem_access_unit #(.MISALIGN_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready0),
        .load_data(load_data0), .load_valid(load_valid0), .exc_misaligned(exc_misaligned0),
        .exc_addr(exc_addr0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0), .dm_read(dm_read0),
        .dm_write(dm_write0), .dm_rdata(dm_rdata0));

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid = v; req_op = op; req_addr = a; req_wdata = d;
    endtask

    task automatic test_reset;
        drive(1'b1, LW, 32'h10, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready, dm_read, dm_write, load_valid, exc_misaligned} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {ready, dm_read, dm_write, load_valid, exc_misaligned});
        end
        checks++;
        if (load_data !== 32'h0 || exc_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: load_data %h exc_addr %h want 0", load_data, exc_addr);
        end
        @(negedge clk);
        drive(1'b0, LW, 32'h10, 32'h0);
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", ready);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  ops  [5] = '{LB, LBU, LH, LHU, LW};
        logic [31:0] adrs [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
        logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899,
                                  32'h00008899, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, ops[i], adrs[i], 32'h0);
            #1;
            checks++;
            if (dm_read !== 1'b1 || dm_write !== 1'b0 || dm_addr !== 32'h10) begin
                errors++;
                $display("FAIL load%0d_mem: rd %b wr %b addr %h want 1 0 00000010",
                         i, dm_read, dm_write, dm_addr);
            end
            @(posedge clk); #1;
            drive(1'b0, LW, 32'h0, 32'h0);
            checks++;
            if (load_valid !== 1'b1 || load_data !== exps[i]) begin
                errors++;
                $display("FAIL load%0d_data: valid %b data %h want 1 %h",
                         i, load_valid, load_data, exps[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (load_valid !== 1'b0) begin
            errors++; $display("FAIL load_pulse: load_valid %b want 0", load_valid);
        end
    endtask

    task automatic test_sub_store;
        @(negedge clk);
        drive(1'b1, SB, 32'h13, 32'h000000CC);
        #1;
        checks++;
        if (ready !== 1'b1 || dm_read !== 1'b1 || dm_write !== 1'b0) begin
            errors++;
            $display("FAIL sb_accept: rdy %b rd %b wr %b want 1 1 0", ready, dm_read, dm_write);
        end
        @(posedge clk); #1;
        drive(1'b0, LW, 32'h0, 32'h0);
        checks++;
        if (ready !== 1'b0 || dm_write !== 1'b1 || dm_read !== 1'b0 ||
            dm_wdata !== 32'hCC99AABB || dm_addr !== 32'h10) begin
            errors++;
            $display("FAIL sb_rmw: rdy %b wr %b rd %b wdata %h addr %h want 0 1 0 cc99aabb 10",
                     ready, dm_write, dm_read, dm_wdata, dm_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || mem[4] !== 32'hCC99AABB) begin
            errors++;
            $display("FAIL sb_done: rdy %b word %h want 1 cc99aabb", ready, mem[4]);
        end
        @(negedge clk);
        drive(1'b1, LW, 32'h10, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, LW, 32'h0, 32'h0);
        checks++;
        if (load_valid !== 1'b1 || load_data !== 32'hCC99AABB) begin
            errors++;
            $display("FAIL sb_readback: valid %b data %h want 1 cc99aabb", load_valid, load_data);
        end
        // restore the original word, then halfword store into lane 0
        @(negedge clk);
        drive(1'b1, SW, 32'h10, 32'h8899AABB);
        @(negedge clk);
        drive(1'b1, SH, 32'h10, 32'h00001234);
        @(posedge clk); #1;
        drive(1'b0, LW, 32'h0, 32'h0);
        checks++;
        if (dm_write !== 1'b1 || dm_wdata !== 32'h88991234) begin
            errors++;
            $display("FAIL sh_rmw: wr %b wdata %h want 1 88991234", dm_write, dm_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (mem[4] !== 32'h88991234) begin
            errors++; $display("FAIL sh_word: got %h want 88991234", mem[4]);
        end
    endtask

    task automatic test_sw;
        @(negedge clk);
        drive(1'b1, SW, 32'h14, 32'hDEADBEEF);
        #1;
        checks++;
        if (dm_write !== 1'b1 || dm_read !== 1'b0 || dm_wdata !== 32'hDEADBEEF ||
            dm_addr !== 32'h14 || ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_accept: wr %b rd %b wdata %h addr %h rdy %b want 1 0 deadbeef 14 1",
                     dm_write, dm_read, dm_wdata, dm_addr, ready);
        end
        @(posedge clk); #1;
        drive(1'b0, LW, 32'h0, 32'h0);
        checks++;
        if (ready !== 1'b1 || mem[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_done: rdy %b word %h want 1 deadbeef", ready, mem[5]);
        end
    endtask

    task automatic test_misaligned;
        logic [2:0]  ops  [2] = '{LW, SH};
        logic [31:0] adrs [2] = '{32'h12, 32'h11};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, ops[i], adrs[i], 32'h0000FFFF);
            #1;
            checks++;
            if (dm_read !== 1'b0 || dm_write !== 1'b0) begin
                errors++;
                $display("FAIL mis%0d_mem: rd %b wr %b want 0 0", i, dm_read, dm_write);
            end
            @(posedge clk); #1;
            drive(1'b0, LW, 32'h0, 32'h0);
            checks++;
            if (exc_misaligned !== 1'b1 || exc_addr !== adrs[i] || load_valid !== 1'b0) begin
                errors++;
                $display("FAIL mis%0d_exc: exc %b addr %h lv %b want 1 %h 0",
                         i, exc_misaligned, exc_addr, load_valid, adrs[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (exc_misaligned !== 1'b0 || exc_addr !== adrs[i] || mem[4] !== 32'h88991234) begin
                errors++;
                $display("FAIL mis%0d_after: exc %b addr %h word %h want 0 %h 88991234",
                         i, exc_misaligned, exc_addr, mem[4], adrs[i]);
            end
        end
    endtask

    task automatic test_reset_rmw;
        @(negedge clk);
        drive(1'b1, SB, 32'h10, 32'h00000055);
        @(posedge clk); #1;
        drive(1'b0, LW, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        checks++;
        if (dm_write !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw_wr: wr %b rdy %b want 0 0", dm_write, ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (mem[4] !== 32'h88991234 || ready !== 1'b1 || load_data !== 32'h0 ||
            exc_addr !== 32'h0 || load_valid !== 1'b0 || exc_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw_after: word %h rdy %b ld %h ea %h lv %b ex %b want 88991234 1 0 0 0 0",
                     mem[4], ready, load_data, exc_addr, load_valid, exc_misaligned);
        end
    endtask

    task automatic test_no_trap;
        @(negedge clk);
        drive(1'b0, LW, 32'h13, 32'h0);
        req_valid0 = 1'b1;
        #1;
        checks++;
        if (dm_read0 !== 1'b1 || dm_addr0 !== 32'h10) begin
            errors++;
            $display("FAIL notrap_mem: rd %b addr %h want 1 10", dm_read0, dm_addr0);
        end
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        checks++;
        if (load_valid0 !== 1'b1 || load_data0 !== 32'h8899AABB || exc_misaligned0 !== 1'b0) begin
            errors++;
            $display("FAIL notrap_data: lv %b data %h exc %b want 1 8899aabb 0",
                     load_valid0, load_data0, exc_misaligned0);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(1'b1, SB, 32'h12, 32'h00000077);
        @(posedge clk); #1;
        drive(1'b1, LW, 32'h10, 32'h0);
        #1;
        checks++;
        if (ready !== 1'b0 || dm_read !== 1'b0 || dm_write !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: rdy %b rd %b wr %b want 0 0 1", ready, dm_read, dm_write);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || dm_read !== 1'b1 || dm_rdata !== 32'h88771234) begin
            errors++;
            $display("FAIL b2b_accept: rdy %b rd %b rdata %h want 1 1 88771234",
                     ready, dm_read, dm_rdata);
        end
        @(posedge clk); #1;
        drive(1'b0, LW, 32'h0, 32'h0);
        checks++;
        if (load_valid !== 1'b1 || load_data !== 32'h88771234) begin
            errors++;
            $display("FAIL b2b_load: lv %b data %h want 1 88771234", load_valid, load_data);
        end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_sub_store;
        test_sw;
        test_misaligned;
        test_reset_rmw;
        test_no_trap;
        test_back_to_back;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store front-end between the EX/MEM pipeline register and the word-wide data memory.
- Translates lw/lh/lhu/lb/lbu/sw/sh/sb into word accesses: byte-lane extraction with sign/zero extension for loads; read-modify-write for sub-word stores, because the data memory only writes whole words.
- Detects misaligned accesses and stalls upstream for the extra RMW cycle.

Parameters:
- MISALIGN_TRAP, 1, 1: misaligned request raises exc_misaligned with no memory access; 0: low address bits are forced to natural alignment and the access proceeds.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present this cycle
- req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- req_addr  input  32  byte address from ALU
- req_wdata  input  32  store data (sub-word in low bits)
- ready  output  1  unit can accept a request this cycle
- load_data  output  32  extended load result (registered)
- load_valid  output  1  one-cycle pulse, load_data valid
- exc_misaligned  output  1  one-cycle pulse on misaligned request
- exc_addr  output  32  faulting address, held until next exception
- dm_addr  output  32  word-aligned address to data memory
- dm_wdata  output  32  write word to data memory
- dm_read  output  1  memory read enable
- dm_write  output  1  memory write enable (committed on clk edge)
- dm_rdata  input  32  combinational read word from data memory

Behaviour:
- States: IDLE, RMW_WR. ready = (state==IDLE) && !reset.
- Accept = req_valid && ready. Little-endian lanes: byte offset k -> bits [8k+7:8k].
- Alignment: LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0; bytes are always aligned.
- dm_addr = {req_addr[31:2],2'b00} in IDLE; in RMW_WR it is the latched aligned address.
- Loads (IDLE, accepted, aligned):
  - dm_read=1, dm_write=0.
  - Lane selected from dm_rdata; LB/LH sign-extend, LBU/LHU zero-extend.
  - Result registered: load_data/load_valid appear on the cycle after accept (latency 1).
- SW (accepted, aligned): dm_write=1, dm_wdata=req_wdata in the same cycle. Stays in IDLE, no stall.
- SH/SB (accepted, aligned):
  - Accept cycle: dm_read=1, dm_write=0.
  - Merged word = dm_rdata with the target lane(s) replaced by req_wdata[7:0] or [15:0]. Latch merged word and aligned address; go to RMW_WR.
  - RMW_WR: dm_write=1, dm_wdata=merged, dm_read=0, ready=0. Return to IDLE next edge.
  - The request occupies exactly 2 cycles.
- Misaligned, MISALIGN_TRAP=1:
  - dm_read=dm_write=0.
  - Next cycle: exc_misaligned=1 (one cycle) and exc_addr=req_addr.
  - load_valid stays 0. State stays IDLE.
- Misaligned, MISALIGN_TRAP=0: low bits are cleared to alignment and the access proceeds normally. No exception.
- req_valid=0, or req_valid=1 while not ready: no memory enables; request ignored (upstream holds it).
- Reset:
  - load_data=0, load_valid=0, exc_misaligned=0, exc_addr=0, state=IDLE, latched word/address=0.
  - Reset asserted in RMW_WR: dm_write forced 0 that cycle, pending store dropped.
  - ready=0 and all dm_* enables are 0 while reset is high.
- load_valid and exc_misaligned are never high in the same cycle.
- Back-to-back: a request presented the cycle RMW_WR completes is accepted on the following cycle. A load there sees the merged word.

Test Plan:
- Memory word 0x10 = 0x8899AABB:
  - LB 0x11 -> load_data 0xFFFFFFAA, 1 cycle after accept.
  - LBU 0x11 -> 0x000000AA.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x12 -> 0x00008899.
  - LW 0x10 -> 0x8899AABB.
- SB 0x13, wdata 0x000000CC:
  - ready low exactly one cycle; dm_write high only in RMW_WR, dm_wdata 0xCC99AABB.
  - Then LW 0x10 -> 0xCC99AABB.
- SH 0x10, wdata 0x00001234 -> word becomes 0x88991234. SW 0x14, wdata 0xDEADBEEF -> dm_write in accept cycle, ready never drops.
- MISALIGN_TRAP=1:
  - LW 0x12 -> exc_misaligned pulse, exc_addr 0x00000012, no dm_read/dm_write, load_valid 0.
  - SH 0x11 -> same, memory unchanged.
- Reset asserted during RMW_WR of SB 0x10 -> dm_write stays 0, word unchanged, all outputs 0, ready high the cycle after reset deasserts.
- MISALIGN_TRAP=0: LW 0x13 -> reads 0x10, no exception.
